exe_wb_skid_stage: RTL and testbench

Parametrised EXE→WB pipeline stage for the four-stage core: carries the write-back address, write-enable and ALU result from execute to write-back. Unlike a plain pipeline register, it has a valid/ready handshake with a two-entry skid buffer, so WB back-pressure does not create a combinational ready path into EXE. It also adds a synchronous flush and a two-port forwarding lookup that EXE uses for operand bypass.

---
 rtl/exe_wb_skid_stage_pkg.sv | 30 +++
 rtl/wb_fwd_match.sv | 41 ++++
 rtl/exe_wb_skid_stage.sv | 133 +++++++++++++
 tb/tb_exe_wb_skid_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_wb_skid_stage_pkg.sv
// Shared definitions for the EXE->WB skid stage: default widths, the
// control state encoding, and the state-to-occupancy mapping.
package exe_wb_skid_stage_pkg;

    localparam int DSIZE_DEF  = 32;
    localparam int AWIDTH_DEF = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HEAD  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // Entry record at the core's default widths; the stage builds the same
    // layout locally so that overridden DSIZE/AWIDTH stay consistent.
    typedef struct packed {
        logic                  wen;
        logic [AWIDTH_DEF-1:0] waddr;
        logic [DSIZE_DEF-1:0]  data;
    } wb_entry_t;

    function automatic logic [1:0] occupancy_of(input skid_state_e st);
        case (st)
            ST_HEAD: occupancy_of = 2'd1;
            ST_FULL: occupancy_of = 2'd2;
            default: occupancy_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// One forwarding lookup port: picks the youngest valid entry that writes the
// queried register; register 0 never forwards.
module wb_fwd_match #(
    parameter int DSIZE  = 32,
    parameter int AWIDTH = 5
) (
    input  logic              head_valid,
    input  logic              head_wen,
    input  logic [AWIDTH-1:0] head_waddr,
    input  logic [DSIZE-1:0]  head_data,
    input  logic              skid_valid,
    input  logic              skid_wen,
    input  logic [AWIDTH-1:0] skid_waddr,
    input  logic [DSIZE-1:0]  skid_data,
    input  logic [AWIDTH-1:0] raddr,
    output logic              hit,
    output logic [DSIZE-1:0]  data
);

    logic raddr_nz;
    logic head_match;
    logic skid_match;

    assign raddr_nz   = (raddr != '0);
    assign head_match = head_valid & head_wen & raddr_nz & (head_waddr == raddr);
    assign skid_match = skid_valid & skid_wen & raddr_nz & (skid_waddr == raddr);

    // Skid is the younger entry, so it shadows the head.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        if (skid_match) begin
            hit  = 1'b1;
            data = skid_data;
        end else if (head_match) begin
            hit  = 1'b1;
            data = head_data;
        end
    end

endmodule

// File: rtl/exe_wb_skid_stage.sv
// EXE->WB stage with a two-entry skid buffer, synchronous flush and a
// two-port operand-forwarding lookup over the held entries.
module exe_wb_skid_stage
    import exe_wb_skid_stage_pkg::*;
#(
    parameter int DSIZE  = DSIZE_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wen,
    input  logic [AWIDTH-1:0] in_waddr,
    input  logic [DSIZE-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wen,
    output logic [AWIDTH-1:0] out_waddr,
    output logic [DSIZE-1:0]  out_data,
    output logic [1:0]        occupancy,
    input  logic [AWIDTH-1:0] q_raddr0,
    input  logic [AWIDTH-1:0] q_raddr1,
    output logic              fwd_hit0,
    output logic              fwd_hit1,
    output logic [DSIZE-1:0]  fwd_data0,
    output logic [DSIZE-1:0]  fwd_data1
);

    typedef struct packed {
        logic              wen;
        logic [AWIDTH-1:0] waddr;
        logic [DSIZE-1:0]  data;
    } entry_t;

    skid_state_e state_q, state_d;
    entry_t      head_q, head_d;
    entry_t      skid_q, skid_d;
    entry_t      in_entry;
    logic        in_fire;
    logic        out_fire;

    // Handshake: a beat moves when valid and ready are both high at the
    // rising edge; valid never waits on ready, and in_ready is decoded from
    // state alone so WB back-pressure has no combinational path into EXE.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign in_entry  = '{wen: in_wen, waddr: in_waddr, data: in_data};

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_HEAD;
                    head_d  = in_entry;
                end
            end
            ST_HEAD: begin
                if (in_fire && out_fire) begin
                    head_d = in_entry;
                end else if (in_fire) begin
                    state_d = ST_FULL;
                    skid_d  = in_entry;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d = ST_HEAD;
                    head_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush only invalidates; stale data in the registers is harmless.
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign out_wen   = head_q.wen & out_valid;
    assign out_waddr = head_q.waddr;
    assign out_data  = head_q.data;
    assign occupancy = occupancy_of(state_q);

    wb_fwd_match #(.DSIZE(DSIZE), .AWIDTH(AWIDTH)) u_fwd0 (
        .head_valid (out_valid),
        .head_wen   (head_q.wen),
        .head_waddr (head_q.waddr),
        .head_data  (head_q.data),
        .skid_valid (state_q == ST_FULL),
        .skid_wen   (skid_q.wen),
        .skid_waddr (skid_q.waddr),
        .skid_data  (skid_q.data),
        .raddr      (q_raddr0),
        .hit        (fwd_hit0),
        .data       (fwd_data0)
    );

    wb_fwd_match #(.DSIZE(DSIZE), .AWIDTH(AWIDTH)) u_fwd1 (
        .head_valid (out_valid),
        .head_wen   (head_q.wen),
        .head_waddr (head_q.waddr),
        .head_data  (head_q.data),
        .skid_valid (state_q == ST_FULL),
        .skid_wen   (skid_q.wen),
        .skid_waddr (skid_q.waddr),
        .skid_data  (skid_q.data),
        .raddr      (q_raddr1),
        .hit        (fwd_hit1),
        .data       (fwd_data1)
    );

endmodule

// File: tb/tb_exe_wb_skid_stage.sv
// Bench for exe_wb_skid_stage: directed scenarios plus a randomized run,
// all checked against a queue model of the held entries.
module tb_exe_wb_skid_stage;

    localparam int DS = 32;
    localparam int AW = 5;
    localparam int W  = 1 + AW + DS;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          in_wen;
    logic [AW-1:0] in_waddr;
    logic [DS-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_wen;
    logic [AW-1:0] out_waddr;
    logic [DS-1:0] out_data;
    logic [1:0]    occupancy;
    logic [AW-1:0] q_raddr0;
    logic [AW-1:0] q_raddr1;
    logic          fwd_hit0;
    logic          fwd_hit1;
    logic [DS-1:0] fwd_data0;
    logic [DS-1:0] fwd_data1;

    int total = 0;
    int bad   = 0;

    // Model: held entries oldest first, each {wen, waddr, data}; at most two.
    logic [W-1:0] exp_q[$];

    exe_wb_skid_stage #(.DSIZE(DS), .AWIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wen    (in_wen),
        .in_waddr  (in_waddr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_wen   (out_wen),
        .out_waddr (out_waddr),
        .out_data  (out_data),
        .occupancy (occupancy),
        .q_raddr0  (q_raddr0),
        .q_raddr1  (q_raddr1),
        .fwd_hit0  (fwd_hit0),
        .fwd_hit1  (fwd_hit1),
        .fwd_data0 (fwd_data0),
        .fwd_data1 (fwd_data1)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DS-1:0] d, input logic ordy);
        in_valid  = v;
        in_wen    = w;
        in_waddr  = a;
        in_data   = d;
        out_ready = ordy;
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        logic can_take;
        logic has_head;
        can_take = (exp_q.size() < 2);
        has_head = (exp_q.size() > 0);
        @(posedge clk);
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (has_head && out_ready) void'(exp_q.pop_front());
            if (in_valid && can_take) exp_q.push_back({in_wen, in_waddr, in_data});
        end
        #1;
    endtask

    function automatic void model_fwd(input logic [AW-1:0] ra, output logic hit,
                                      output logic [DS-1:0] d);
        logic [W-1:0] e;
        hit = 1'b0;
        d   = '0;
        if (ra != '0) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                e = exp_q[i];
                if (e[W-1] && e[W-2:DS] == ra) begin
                    hit = 1'b1;
                    d   = e[DS-1:0];
                end
            end
        end
    endfunction

    task automatic test_reset();
        flush = 1'b0;
        q_raddr0 = 5'd3;
        q_raddr1 = 5'd9;
        drive(1'b1, 1'b1, 5'd3, 32'hFFFF_0000, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_wen !== 1'b0) begin bad++; $display("FAIL reset_out_wen got=%b want=0", out_wen); end
        total++; if (out_waddr !== 5'd0) begin bad++; $display("FAIL reset_out_waddr got=%0d want=0", out_waddr); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
        total++; if (fwd_hit0 !== 1'b0 || fwd_hit1 !== 1'b0) begin bad++; $display("FAIL reset_fwd_hit got=%b%b want=00", fwd_hit0, fwd_hit1); end
        rst = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        tick();
    endtask

    task automatic test_stream();
        logic [AW-1:0] addrs[3] = '{5'd3, 5'd4, 5'd5};
        logic [DS-1:0] datas[3] = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, addrs[i], datas[i], 1'b1);
            tick();
            total++; if (out_valid !== 1'b1 || out_waddr !== addrs[i] || out_data !== datas[i])
                begin bad++; $display("FAIL stream_beat%0d got=%b/%0d/%h want=1/%0d/%h", i, out_valid, out_waddr, out_data, addrs[i], datas[i]); end
            total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL stream_occ%0d got=%0d want=1", i, occupancy); end
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        tick();
        total++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0d/%b want=0/0", occupancy, out_valid); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b1, 5'd7, 32'hAA, 1'b0);
        tick();
        total++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_first got=%0d/%b want=1/1", occupancy, in_ready); end
        drive(1'b1, 1'b1, 5'd8, 32'hBB, 1'b0);
        tick();
        total++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%0d/%b want=2/0", occupancy, in_ready); end
        drive(1'b1, 1'b1, 5'd9, 32'hCC, 1'b0);
        tick();
        total++; if (occupancy !== 2'd2 || out_data !== 32'hAA) begin bad++; $display("FAIL bp_hold got=%0d/%h want=2/aa", occupancy, out_data); end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_comb_ready got=%b want=0", in_ready); end
        tick();
        total++; if (out_data !== 32'hBB || out_waddr !== 5'd8 || occupancy !== 2'd1 || in_ready !== 1'b1)
            begin bad++; $display("FAIL bp_second got=%h/%0d/%0d/%b want=bb/8/1/1", out_data, out_waddr, occupancy, in_ready); end
        tick();
        total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL bp_empty got=%b/%0d want=0/0", out_valid, occupancy); end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 5'd10, 32'h1010, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd11, 32'h1111, 1'b0);
        tick();
        q_raddr0 = 5'd12;
        flush = 1'b1;
        drive(1'b1, 1'b1, 5'd12, 32'hDEAD, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        #1;
        total++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_wen !== 1'b0)
            begin bad++; $display("FAIL flush_state got=%b/%0d/%b/%b want=0/0/1/0", out_valid, occupancy, in_ready, out_wen); end
        total++; if (fwd_hit0 !== 1'b0) begin bad++; $display("FAIL flush_fwd got=%b want=0", fwd_hit0); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost%0d got=%b want=0", i, out_valid); end
        end
    endtask

    task automatic test_fwd_priority();
        drive(1'b1, 1'b1, 5'd9, 32'h100, 1'b0);
        tick();
        q_raddr0 = 5'd9;
        q_raddr1 = 5'd9;
        #1;
        total++; if (fwd_hit0 !== 1'b1 || fwd_data0 !== 32'h100) begin bad++; $display("FAIL fwd_head got=%b/%h want=1/100", fwd_hit0, fwd_data0); end
        drive(1'b1, 1'b1, 5'd9, 32'h200, 1'b0);
        tick();
        total++; if (fwd_hit0 !== 1'b1 || fwd_data0 !== 32'h200) begin bad++; $display("FAIL fwd_skid_p0 got=%b/%h want=1/200", fwd_hit0, fwd_data0); end
        total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h200) begin bad++; $display("FAIL fwd_skid_p1 got=%b/%h want=1/200", fwd_hit1, fwd_data1); end
        flush = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b1, 1'b1, 5'd0, 32'h55, 1'b0);
        tick();
        q_raddr1 = 5'd0;
        #1;
        total++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'd0) begin bad++; $display("FAIL fwd_r0 got=%b/%h want=0/0", fwd_hit1, fwd_data1); end
        flush = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        flush = 1'b0;
    endtask

    task automatic test_wen0();
        drive(1'b1, 1'b0, 5'd4, 32'h4444, 1'b0);
        tick();
        q_raddr0 = 5'd4;
        #1;
        total++; if (fwd_hit0 !== 1'b0 || out_wen !== 1'b0 || out_valid !== 1'b1)
            begin bad++; $display("FAIL wen0 got hit=%b wen=%b valid=%b want 0/0/1", fwd_hit0, out_wen, out_valid); end
    endtask

    task automatic test_reset_full();
        drive(1'b1, 1'b1, 5'd6, 32'h66, 1'b0);
        tick();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL rstfull_fill got=%0d want=2", occupancy); end
        q_raddr0 = 5'd6;
        rst = 1'b1;
        drive(1'b1, 1'b1, 5'd7, 32'h77, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        #1;
        total++; if (out_valid !== 1'b0 || out_wen !== 1'b0 || out_waddr !== 5'd0 || out_data !== 32'd0)
            begin bad++; $display("FAIL rstfull_out got=%b/%b/%0d/%h want=0/0/0/0", out_valid, out_wen, out_waddr, out_data); end
        total++; if (in_ready !== 1'b1 || occupancy !== 2'd0 || fwd_hit0 !== 1'b0)
            begin bad++; $display("FAIL rstfull_ctl got=%b/%0d/%b want=1/0/0", in_ready, occupancy, fwd_hit0); end
    endtask

    task automatic test_random();
        logic          e_hit0, e_hit1;
        logic [DS-1:0] e_d0, e_d1;
        logic [W-1:0]  h;
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 24) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)),
                  $urandom, $urandom_range(0, 2) != 0);
            q_raddr0 = AW'($urandom_range(0, 7));
            q_raddr1 = AW'($urandom_range(0, 7));
            tick();
            rst   = 1'b0;
            flush = 1'b0;
            #1;
            model_fwd(q_raddr0, e_hit0, e_d0);
            model_fwd(q_raddr1, e_hit1, e_d1);
            total++; if (in_ready !== (exp_q.size() < 2)) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%b want=%b", c, in_ready, exp_q.size() < 2); end
            total++; if (occupancy !== 2'(exp_q.size())) begin bad++; $display("FAIL rnd_occ c=%0d got=%0d want=%0d", c, occupancy, exp_q.size()); end
            total++; if (out_valid !== (exp_q.size() > 0)) begin bad++; $display("FAIL rnd_out_valid c=%0d got=%b", c, out_valid); end
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                total++; if ({out_wen, out_waddr, out_data} !== h)
                    begin bad++; $display("FAIL rnd_head c=%0d got=%b/%0d/%h want=%b/%0d/%h", c, out_wen, out_waddr, out_data, h[W-1], h[W-2:DS], h[DS-1:0]); end
            end else begin
                total++; if (out_wen !== 1'b0) begin bad++; $display("FAIL rnd_out_wen_idle c=%0d got=%b want=0", c, out_wen); end
            end
            total++; if (fwd_hit0 !== e_hit0 || fwd_data0 !== e_d0)
                begin bad++; $display("FAIL rnd_fwd0 c=%0d got=%b/%h want=%b/%h", c, fwd_hit0, fwd_data0, e_hit0, e_d0); end
            total++; if (fwd_hit1 !== e_hit1 || fwd_data1 !== e_d1)
                begin bad++; $display("FAIL rnd_fwd1 c=%0d got=%b/%h want=%b/%h", c, fwd_hit1, fwd_data1, e_hit1, e_d1); end
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        q_raddr0 = '0;
        q_raddr1 = '0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_fwd_priority();
        test_wen0();
        test_reset_full();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
